// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM state encoding,
// engine configuration field widths and a helper for index widths.
package spi_arb_pkg;

    localparam int MODE_W = 2;   // CPOL/CPHA
    localparam int BAUD_W = 12;  // baud-rate divisor
    localparam int GAP_W  = 4;   // holds GAP_CYCLES-1 for GAP_CYCLES up to 15

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_TIP,
        WAIT_DONE,
        COMPLETE,
        GAP
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_pick.sv
// Combinational round-robin picker.
// Returns the first set bit of req_i at or above ptr_i, searching upward
// with wrap-around.
// Ports:
//   req_i  [NUM_REQ-1:0]  request vector
//   ptr_i  [IDX_W-1:0]    search start position
//   gnt_o  [NUM_REQ-1:0]  one-hot winner (zero when no request)
//   idx_o  [IDX_W-1:0]    index of the winner
//   any_o                 at least one request present
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               k;
    logic [IDX_W-1:0] kk;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kk = IDX_W'(k);
            if (!any_o && req_i[kk]) begin
                any_o     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin scheduler that shares one SPI master transfer engine among
// NUM_REQ requesters. Loads the winner's mode/divisor/TX byte onto the
// engine, pulses send_data_o, waits for the engine to finish and returns
// the received byte plus a done pulse to the winner.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a per-transfer
// watchdog (TIMEOUT_CYCLES, must be >= 2); otherwise err_o is tied low and
// the FSM waits for the engine indefinitely.
//
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   req_i / req_data_i /
//   req_mode_i / req_baud_i      per-requester request and configuration
//   spiswai_i                    wait mode, blocks new grants only
//   tip_i, receive_data_i,
//   rx_data_i                    engine status and received byte
//   send_data_o, data_o,
//   spi_mode_o,
//   BaudRateDivisor_o, mstr_o    engine controls
//   gnt_o, done_o, rx_data_o     requester-side grant/completion/data
//   busy_o, err_o                status
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no transfer; arbitration among requests
// LAUNCH    | config loaded, one-cycle send pulse to the engine
// WAIT_TIP  | waiting for the engine to report transfer in progress
// WAIT_DONE | transfer running, waiting for receive-complete
// COMPLETE  | done pulse to the winner, pointer advances
// GAP       | forced idle spacing before the next arbitration
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ*MODE_W-1:0] req_mode_i,
    input  logic [NUM_REQ*BAUD_W-1:0] req_baud_i,
    input  logic                      spiswai_i,
    input  logic                      tip_i,
    input  logic                      receive_data_i,
    input  logic [DATA_W-1:0]         rx_data_i,
    output logic                      send_data_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [MODE_W-1:0]         spi_mode_o,
    output logic [BAUD_W-1:0]         BaudRateDivisor_o,
    output logic                      mstr_o,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("spi_xfer_arbiter: NUM_REQ must be 2..8");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("spi_xfer_arbiter: GAP_CYCLES must be 0..15");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("spi_xfer_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] win_q, win_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               tmo_hit;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            win_q     <= '0;
            win_idx_q <= '0;
            ptr_q     <= '0;
            data_q    <= '0;
            rx_q      <= '0;
            mode_q    <= '0;
            baud_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            win_idx_q <= win_idx_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            rx_q      <= rx_d;
            mode_q    <= mode_d;
            baud_q    <= baud_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        win_idx_d = win_idx_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        rx_d      = rx_q;
        mode_d    = mode_q;
        baud_d    = baud_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_any && !spiswai_i) begin
                    state_d   = LAUNCH;
                    win_d     = pick_gnt;
                    win_idx_d = pick_idx;
                    data_d    = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
                    mode_d    = req_mode_i[int'(pick_idx)*MODE_W +: MODE_W];
                    baud_d    = req_baud_i[int'(pick_idx)*BAUD_W +: BAUD_W];
                end
            end
            LAUNCH: begin
                state_d = WAIT_TIP;
            end
            // A completion strobe beats the watchdog; the watchdog beats tip
            // so its terminal count is never skipped.
            WAIT_TIP: begin
                if (receive_data_i) begin
                    state_d = COMPLETE;
                    rx_d    = rx_data_i;
                end else if (tmo_hit) begin
                    state_d = COMPLETE;
                end else if (tip_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (receive_data_i) begin
                    state_d = COMPLETE;
                    rx_d    = rx_data_i;
                end else if (tmo_hit) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                ptr_d   = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                gap_d   = GAP_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // Loaded in LAUNCH so the terminal count of 1 lands on the last wait
    // cycle, putting COMPLETE exactly TIMEOUT_CYCLES cycles after LAUNCH.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == LAUNCH) begin
            tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
            err_q <= 1'b0;
        end else if (state_q == WAIT_TIP || state_q == WAIT_DONE) begin
            if (tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
            if (tmo_hit && !receive_data_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit = (state_q == WAIT_TIP || state_q == WAIT_DONE) && (tmo_q == TMO_W'(1));
    assign err_o   = (state_q == COMPLETE) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign send_data_o       = (state_q == LAUNCH);
    assign gnt_o             = (state_q == LAUNCH || state_q == WAIT_TIP || state_q == WAIT_DONE) ? win_q : '0;
    assign done_o            = (state_q == COMPLETE) ? win_q : '0;
    assign busy_o            = (state_q != IDLE);
    assign mstr_o            = 1'b1;
    assign data_o            = data_q;
    assign spi_mode_o        = mode_q;
    assign BaudRateDivisor_o = baud_q;
    assign rx_data_o         = rx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;

    localparam int N    = 4;
    localparam int GAPC = 3;
    localparam int TMO  = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [3:0]  req_i = '0;
    logic [31:0] req_data_i = {8'h96, 8'h5E, 8'h17, 8'hA5};
    logic [7:0]  req_mode_i = {2'd3, 2'd2, 2'd1, 2'd0};
    logic [47:0] req_baud_i = {12'h7FF, 12'h0FF, 12'h101, 12'h002};
    logic        spiswai_i = 1'b0;
    logic        tip_i = 1'b0;
    logic        receive_data_i = 1'b0;
    logic [7:0]  rx_data_i = 8'hEE;

    logic        send_data_o;
    logic [7:0]  data_o;
    logic [1:0]  spi_mode_o;
    logic [11:0] BaudRateDivisor_o;
    logic        mstr_o;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic [7:0]  rx_data_o;
    logic        busy_o;
    logic        err_o;

    spi_xfer_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (8),
        .GAP_CYCLES     (GAPC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .req_i             (req_i),
        .req_data_i        (req_data_i),
        .req_mode_i        (req_mode_i),
        .req_baud_i        (req_baud_i),
        .spiswai_i         (spiswai_i),
        .tip_i             (tip_i),
        .receive_data_i    (receive_data_i),
        .rx_data_i         (rx_data_i),
        .send_data_o       (send_data_o),
        .data_o            (data_o),
        .spi_mode_o        (spi_mode_o),
        .BaudRateDivisor_o (BaudRateDivisor_o),
        .mstr_o            (mstr_o),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .rx_data_o         (rx_data_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // ---------------- behavioural model (timestamps, not states) -------------
    // A transfer is "active" from its launch cycle until its completion cycle;
    // the arbiter is free to launch again once cycle m_free is reached.
    bit          m_active = 0;
    int          m_win = 0, m_ptr = 0;
    int          m_launch = -100, m_done = -100, m_free = 0;
    bit          m_err = 0;
    logic [7:0]  m_data = '0, m_rx = '0;
    logic [1:0]  m_mode = '0;
    logic [11:0] m_baud = '0;
    int          mk;
    bit          mfound;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_active = 0; m_win = 0; m_ptr = 0;
            m_launch = -100; m_done = -100; m_free = 0; m_err = 0;
            m_data = '0; m_rx = '0; m_mode = '0; m_baud = '0;
        end else begin
            cyc++;
            if (m_active && (cyc - 1 > m_launch) && receive_data_i) begin
                m_active = 0; m_done = cyc; m_err = 0; m_rx = rx_data_i;
                m_ptr = (m_win + 1) % N; m_free = cyc + 1 + GAPC;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (m_active && cyc == m_launch + TMO) begin
                m_active = 0; m_done = cyc; m_err = 1;
                m_ptr = (m_win + 1) % N; m_free = cyc + 1 + GAPC;
            end
`endif
            else if (!m_active && (cyc - 1 >= m_free) && req_i != 0 && !spiswai_i) begin
                mfound = 0;
                for (int i = 0; i < N; i++) begin
                    mk = (m_ptr + i) % N;
                    if (!mfound && req_i[mk]) begin
                        mfound = 1;
                        m_win = mk;
                    end
                end
                m_active = 1; m_launch = cyc;
                m_data = req_data_i[m_win*8 +: 8];
                m_mode = req_mode_i[m_win*2 +: 2];
                m_baud = req_baud_i[m_win*12 +: 12];
            end
        end
    end

    // ---------------- engine model --------------------------------------------
    int         eng_tip_dly = 2, eng_rx_dly = 4, eng_k = 0;
    logic [7:0] eng_rx = 8'h3C;
    bit         eng_mute = 0, eng_run = 0;

    always @(negedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            eng_run = 0; tip_i = 0; receive_data_i = 0; rx_data_i = 8'hEE;
        end else begin
            receive_data_i = 0;
            rx_data_i = 8'hEE;
            if (send_data_o) begin
                eng_run = !eng_mute;
                eng_k = 0;
            end else if (eng_run) begin
                eng_k++;
                if (eng_k == eng_rx_dly) begin
                    receive_data_i = 1; rx_data_i = eng_rx; tip_i = 0; eng_run = 0;
                end else if (eng_k >= eng_tip_dly) begin
                    tip_i = 1;
                end
            end
        end
    end

    // ---------------- event recorder + per-cycle compare --------------------
    int   send_cyc[$], send_idx[$], done_cyc[$];
    logic [3:0] done_oh[$];
    logic done_err[$];

    function automatic int onehot_idx(input logic [3:0] v);
        onehot_idx = -1;
        for (int i = 0; i < 4; i++) if (v[i]) onehot_idx = i;
    endfunction

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (send_data_o) begin
                send_cyc.push_back(cyc);
                send_idx.push_back(onehot_idx(gnt_o));
            end
            if (done_o != 0) begin
                done_cyc.push_back(cyc);
                done_oh.push_back(done_o);
                done_err.push_back(err_o);
            end
            chk("send_data_o", send_data_o, cyc == m_launch);
            chk("gnt_o", gnt_o, m_active ? (4'b1 << m_win) : 4'b0);
            chk("done_o", done_o, (cyc == m_done) ? (4'b1 << m_win) : 4'b0);
            chk("busy_o", busy_o, m_active || cyc < m_free);
            chk("err_o", err_o, (cyc == m_done) && m_err);
            chk("data_o", data_o, m_data);
            chk("spi_mode_o", spi_mode_o, m_mode);
            chk("BaudRateDivisor_o", BaudRateDivisor_o, m_baud);
            chk("rx_data_o", rx_data_o, m_rx);
            chk("mstr_o", mstr_o, 1'b1);
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge PCLK);
            #1;
        end
    endtask

    task automatic clear_q();
        send_cyc.delete(); send_idx.delete(); done_cyc.delete();
        done_oh.delete(); done_err.delete();
    endtask

    task automatic do_reset();
        PRESET = 1; req_i = '0; spiswai_i = 0;
        tick(2);
        PRESET = 0;
        tick(1);
        clear_q();
    endtask

    task automatic wait_sends(input int n, input int lim);
        int k = 0;
        while (send_cyc.size() < n) begin
            if (k == lim) begin
                n_checks++; n_fail++;
                $display("FAIL wait_send: actual=%0d sends required=%0d", send_cyc.size(), n);
                summary();
            end
            tick(1); k++;
        end
    endtask

    task automatic wait_dones(input int n, input int lim);
        int k = 0;
        while (done_cyc.size() < n) begin
            if (k == lim) begin
                n_checks++; n_fail++;
                $display("FAIL wait_done: actual=%0d dones required=%0d", done_cyc.size(), n);
                summary();
            end
            tick(1); k++;
        end
    endtask

    int c0, lc, wc;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset state while PRESET is held
        #1;
        chk("rst_send", send_data_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_gnt", gnt_o, 4'b0);
        chk("rst_mstr", mstr_o, 1'b1);
        chk("rst_data", data_o, 8'h00);
        do_reset();

        // single transfer
        eng_tip_dly = 2; eng_rx_dly = 4; eng_rx = 8'h3C;
        tick(2);
        c0 = cyc;
        req_i = 4'b0001;
        wait_dones(1, 40);
        req_i = 4'b0000;
        chk("t1_send_cycle", send_cyc[0], c0 + 1);
        chk("t1_data", data_o, 8'hA5);
        chk("t1_baud", BaudRateDivisor_o, 12'h002);
        chk("t1_mode", spi_mode_o, 2'd0);
        chk("t1_done", done_oh[0], 4'b0001);
        chk("t1_done_cycle", done_cyc[0], c0 + 6);
        chk("t1_rx", rx_data_o, 8'h3C);
        tick(3);
        chk("t1_busy_before_fall", busy_o, 1'b1);
        tick(1);
        chk("t1_busy_fall", busy_o, 1'b0);
        tick(8);
        chk("t1_done_count", done_cyc.size(), 1);

        // fairness from reset, pointer wraps to requester 0
        do_reset();
        eng_tip_dly = 1; eng_rx_dly = 3; eng_rx = 8'h11;
        req_i = 4'b1111;
        wait_dones(5, 200);
        req_i = 4'b0000;
        for (int i = 0; i < 5; i++) chk("t2_grant_order", send_idx[i], exp_order[i]);
        chk("t2_gap_spacing", send_cyc[1] - done_cyc[0], GAPC + 2);
        chk("t2_last_data", data_o, 8'hA5);
        tick(12);

        // wait mode blocks new grants
        clear_q();
        spiswai_i = 1;
        req_i = 4'b0100;
        tick(20);
        chk("t3_no_send", send_cyc.size(), 0);
        wc = cyc;
        spiswai_i = 0;
        wait_dones(1, 40);
        req_i = 4'b0000;
        chk("t3_send_cycle", send_cyc[0], wc + 1);
        chk("t3_grant", send_idx[0], 2);
        chk("t3_baud", BaudRateDivisor_o, 12'h0FF);
        tick(12);

        // requester drops during WAIT_DONE
        clear_q();
        eng_tip_dly = 1; eng_rx_dly = 6; eng_rx = 8'h5A;
        req_i = 4'b0010;
        wait_sends(1, 20);
        lc = send_cyc[0];
        tick(3);
        req_i = 4'b0000;
        wait_dones(1, 40);
        chk("t4_done", done_oh[0], 4'b0010);
        chk("t4_done_cycle", done_cyc[0], lc + 7);
        chk("t4_rx", rx_data_o, 8'h5A);
        tick(15);
        chk("t4_no_regrant", send_cyc.size(), 1);

        // completion while still in WAIT_TIP, wait mode raised mid-transfer
        clear_q();
        eng_tip_dly = 100; eng_rx_dly = 3; eng_rx = 8'hC3;
        req_i = 4'b1000;
        wait_sends(1, 20);
        lc = send_cyc[0];
        spiswai_i = 1;
        wait_dones(1, 40);
        chk("t5_done_cycle", done_cyc[0], lc + 4);
        chk("t5_done", done_oh[0], 4'b1000);
        chk("t5_rx", rx_data_o, 8'hC3);
        tick(12);
        chk("t5_held_off", send_cyc.size(), 1);
        spiswai_i = 0;
        wait_dones(2, 40);
        req_i = 4'b0000;
        chk("t5_relaunch_idx", send_idx[1], 3);
        tick(12);

        // asynchronous reset in WAIT_DONE
        clear_q();
        eng_tip_dly = 1; eng_rx_dly = 10; eng_rx = 8'h99;
        req_i = 4'b0001;
        wait_sends(1, 20);
        tick(4);
        chk("t6_busy_pre", busy_o, 1'b1);
        #2 PRESET = 1;
        #1;
        chk("t6_send", send_data_o, 1'b0);
        chk("t6_gnt", gnt_o, 4'b0);
        chk("t6_done", done_o, 4'b0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_err", err_o, 1'b0);
        chk("t6_data", data_o, 8'h00);
        chk("t6_rx", rx_data_o, 8'h00);
        chk("t6_mode", spi_mode_o, 2'd0);
        chk("t6_baud", BaudRateDivisor_o, 12'h000);
        chk("t6_mstr", mstr_o, 1'b1);
        req_i = 4'b0000;
        tick(2);
        PRESET = 0;
        tick(5);
        chk("t6_idle_after", busy_o, 1'b0);
        chk("t6_no_done", done_cyc.size(), 0);

`ifdef SPI_ARB_TIMEOUT_EN
        // watchdog: engine never answers
        clear_q();
        eng_tip_dly = 1; eng_rx_dly = 3; eng_rx = 8'h77;
        req_i = 4'b0100;
        wait_dones(1, 40);
        req_i = 4'b0000;
        chk("t7_pre_rx", rx_data_o, 8'h77);
        tick(12);
        clear_q();
        eng_mute = 1;
        req_i = 4'b0001;
        wait_dones(1, 60);
        req_i = 4'b0000;
        chk("t7_tmo_cycles", done_cyc[0] - send_cyc[0], TMO);
        chk("t7_err", done_err[0], 1'b1);
        chk("t7_done", done_oh[0], 4'b0001);
        chk("t7_rx_kept", rx_data_o, 8'h77);
        eng_mute = 0;
        tick(12);
`else
        // no watchdog: silent engine keeps the arbiter waiting
        do_reset();
        eng_mute = 1;
        req_i = 4'b0001;
        tick(40);
        chk("t7_no_done", done_cyc.size(), 0);
        chk("t7_busy", busy_o, 1'b1);
        chk("t7_gnt", gnt_o, 4'b0001);
        chk("t7_err", err_o, 1'b0);
        do_reset();
        eng_mute = 0;
        tick(4);
`endif

        summary();
    end

endmodule
